multdiv_stall_ctrl: RTL and testbench

//   Pipeline controller for the shared multi-cycle mult/div unit and load-use interlock.
//   - Decodes the D/X instruction; on mul/div, starts the multdiv unit and freezes F/D and D/X.
//   - Waits for ready or timeout, then releases the pipe with a one-cycle result-latch pulse.
//   - Sits beside the bypass network; its stall/bubble outputs gate the PC, F/D and D/X latches.

---
 rtl/multdiv_stall_ctrl.sv | 154 +++++++++++++++
 tb/tb_multdiv_stall_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_stall_ctrl.sv
// Mult/div issue + load-use interlock; optional load-use stall under `PIPE_LOAD_USE_EN.
// Latency: start pulse same cycle as decode; md_latch one cycle after md_ready or MD_TIMEOUT BUSY cycles.
// Backpressure: freezes PC/F-D/D-X and bubbles X/M while the multdiv unit is busy; no input flow control.
module multdiv_stall_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        flush,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        bubble_xm,
    output logic        md_latch,
    output logic        md_busy,
    output logic        md_timeout
);

    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          rst_q;

    logic [4:0] dx_op, dx_aluop;
    logic       dx_md;

    assign dx_op    = dx_ir[31:27];
    assign dx_aluop = dx_ir[6:2];
    assign dx_md    = (dx_op == 5'b00000) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

`ifdef PIPE_LOAD_USE_EN
    logic [4:0] dx_rd, fd_op, fd_rs, fd_srcb;
    logic       fd_srcb_vld, load_use;
    logic       unused_bits;

    assign dx_rd = dx_ir[26:22];
    assign fd_op = fd_ir[31:27];
    assign fd_rs = fd_ir[21:17];

    always_comb begin
        fd_srcb     = 5'd0;
        fd_srcb_vld = 1'b0;
        if (fd_op == 5'b00000) begin
            fd_srcb     = fd_ir[16:12];
            fd_srcb_vld = 1'b1;
        end else if ((fd_op == 5'b00010) || (fd_op == 5'b00110) ||
                     (fd_op == 5'b00111) || (fd_op == 5'b00100)) begin
            fd_srcb     = fd_ir[26:22];
            fd_srcb_vld = 1'b1;
        end
    end

    // rd != 0 also discards matches on r0 for both sources
    assign load_use = (dx_op == 5'b01000) && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_rs) || (fd_srcb_vld && (dx_rd == fd_srcb)));
    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fd_ir, dx_ir[26:7], dx_ir[1:0]};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rst_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        stall_fd   = 1'b0;
        stall_dx   = 1'b0;
        bubble_dx  = 1'b0;
        bubble_xm  = 1'b0;
        md_latch   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;

        // First cycle out of reset is quiet even if D/X still holds a mul/div
        if (rst_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_d = 1'b0;
                    if (dx_md && !flush) begin
                        ctrl_mult = (dx_aluop == ALU_MUL);
                        ctrl_div  = (dx_aluop == ALU_DIV);
                        stall_fd  = 1'b1;
                        stall_dx  = 1'b1;
                        bubble_xm = 1'b1;
                        cnt_d     = '0;
                        state_d   = BUSY;
                    end
`ifdef PIPE_LOAD_USE_EN
                    else if (load_use && !flush) begin
                        stall_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end
`endif
                end
                BUSY: begin
                    md_busy   = 1'b1;
                    stall_fd  = 1'b1;
                    stall_dx  = 1'b1;
                    bubble_xm = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (md_ready) begin
                        tmo_d   = 1'b0;
                        state_d = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    md_busy    = 1'b1;
                    md_latch   = 1'b1;
                    md_timeout = tmo_q;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Scoreboarded bench for multdiv_stall_ctrl: directed scenarios followed by randomized traffic.
module tb_multdiv_stall_ctrl;

    localparam int MD_TIMEOUT = 40;
`ifdef PIPE_LOAD_USE_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir;
    logic        flush, md_ready;
    logic        ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, bubble_xm;
    logic        md_latch, md_busy, md_timeout;

    always #5 clock = ~clock;

    multdiv_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .flush(flush), .md_ready(md_ready),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall_fd(stall_fd),
        .stall_dx(stall_dx), .bubble_dx(bubble_dx), .bubble_xm(bubble_xm),
        .md_latch(md_latch), .md_busy(md_busy), .md_timeout(md_timeout)
    );

    // {ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, bubble_xm, md_latch, md_busy, md_timeout}
    typedef logic [8:0] vec_t;
    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: "is an op in flight, how many busy cycles has it had, is a result due"
    bit m_known = 0, m_after_rst = 0, m_inflight = 0, m_latch = 0, m_latch_tmo = 0;
    int m_age = 0;
    logic        p_reset = 1'b1, p_flush = 1'b0, p_ready = 1'b0;
    logic [31:0] p_dx = '0;
    vec_t        last_exp = '0;

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic bit is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
    endfunction

    function automatic bit lu_hazard(input logic [31:0] dx, input logic [31:0] fd);
        logic [4:0] rd, op;
        bit hit;
        rd  = dx[26:22];
        op  = fd[31:27];
        hit = (rd == fd[21:17]);
        if (op == 5'd0) hit = hit || (rd == fd[16:12]);
        else if (op == 5'd2 || op == 5'd6 || op == 5'd7 || op == 5'd4) hit = hit || (rd == fd[26:22]);
        return (dx[31:27] == 5'd8) && (rd != 5'd0) && hit;
    endfunction

    function automatic vec_t expect_now(input logic [31:0] dx, input logic [31:0] fd, input logic fl);
        bit cm = 0, cd = 0, sf = 0, sd = 0, bd = 0, bx = 0, lt = 0, bz = 0, to = 0;
        if (m_after_rst) begin
        end else if (m_latch) begin
            lt = 1; bz = 1; to = m_latch_tmo;
        end else if (m_inflight) begin
            sf = 1; sd = 1; bx = 1; bz = 1;
        end else if (is_md(dx) && !fl) begin
            cm = (dx[6:2] == 5'd6); cd = !cm; sf = 1; sd = 1; bx = 1;
        end else if (LU_EN && !fl && lu_hazard(dx, fd)) begin
            sf = 1; bd = 1;
        end
        return {cm, cd, sf, sd, bd, bx, lt, bz, to};
    endfunction

    task automatic model_step();
        if (p_reset) begin
            m_known = 1; m_after_rst = 1; m_inflight = 0; m_latch = 0; m_latch_tmo = 0; m_age = 0;
        end else if (m_after_rst) begin
            m_after_rst = 0;
        end else if (m_latch) begin
            m_latch = 0;
        end else if (m_inflight) begin
            m_age++;
            if (p_ready) begin
                m_inflight = 0; m_latch = 1; m_latch_tmo = 0;
            end else if (m_age == MD_TIMEOUT) begin
                m_inflight = 0; m_latch = 1; m_latch_tmo = 1;
            end
        end else if (is_md(p_dx) && !p_flush) begin
            m_inflight = 1; m_age = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic apply(input logic r, input logic [31:0] dx, input logic [31:0] fd,
                         input logic fl, input logic rdy);
        reset = r; dx_ir = dx; fd_ir = fd; flush = fl; md_ready = rdy;
        last_exp = expect_now(dx, fd, fl);
        if (m_known) exp_q.push_back(last_exp);
        p_reset = r; p_dx = dx; p_flush = fl; p_ready = rdy;
    endtask

    task automatic step(input logic r, input logic [31:0] dx, input logic [31:0] fd,
                        input logic fl, input logic rdy);
        tick();
        apply(r, dx, fd, fl, rdy);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs, rt;
        rd = 5'($urandom_range(0, 7));
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: return mk(5'd0, rd, rs, rt, 5'd6);
            1: return mk(5'd0, rd, rs, rt, 5'd7);
            2: return mk(5'd8, rd, rs, rt, 5'd0);
            3: return mk(5'd0, rd, rs, rt, 5'd0);
            4: return mk(5'd5, rd, rs, rt, 5'd0);
            default: return mk(5'($urandom_range(0, 7)), rd, rs, rt, 5'd0);
        endcase
    endfunction

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            vec_t e, a;
            e = exp_q.pop_front();
            a = {ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, bubble_xm, md_latch, md_busy, md_timeout};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs vector %0d at %0t: got %b expected %b", vectors, $time, a, e);
            end
        end
    end

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        logic [31:0] mul_i, div_i, lw5, add_i, lw0, add0, sw_i, cur_dx;
        int rdelay;
        mul_i = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);
        div_i = mk(5'd0, 5'd4, 5'd1, 5'd2, 5'd7);
        lw5   = mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0);
        add_i = mk(5'd0, 5'd6, 5'd5, 5'd7, 5'd0);
        lw0   = mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0);
        add0  = mk(5'd0, 5'd6, 5'd0, 5'd7, 5'd0);
        sw_i  = mk(5'd7, 5'd5, 5'd2, 5'd0, 5'd0);

        reset = 1'b1; dx_ir = NOP; fd_ir = NOP; flush = 1'b0; md_ready = 1'b0;
        repeat (3) step(1'b1, NOP, NOP, 1'b0, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // mul, ready 5 cycles after the start pulse
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        repeat (4) step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, mul_i, NOP, 1'b0, 1'b1);
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // div with no ready: forced completion; late ready in IDLE ignored
        step(1'b0, div_i, NOP, 1'b0, 1'b0);
        repeat (MD_TIMEOUT + 1) step(1'b0, div_i, NOP, 1'b0, 1'b0);
        repeat (2) step(1'b0, NOP, NOP, 1'b0, 1'b1);

        // flush in the issue cycle suppresses the issue
        step(1'b0, mul_i, NOP, 1'b1, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // reset on the 3rd busy cycle, mul still in D/X afterwards
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        repeat (2) step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b1, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, mul_i, NOP, 1'b0, 1'b1);
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // back-to-back mul then div, ready after 3 each; ready on issue cycle ignored
        step(1'b0, mul_i, NOP, 1'b0, 1'b1);
        repeat (2) step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, mul_i, NOP, 1'b0, 1'b1);
        step(1'b0, mul_i, NOP, 1'b0, 1'b0);
        step(1'b0, div_i, NOP, 1'b0, 1'b0);
        repeat (2) step(1'b0, div_i, NOP, 1'b0, 1'b0);
        step(1'b0, div_i, NOP, 1'b0, 1'b1);
        step(1'b0, div_i, NOP, 1'b0, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // load-use patterns
        step(1'b0, lw5, add_i, 1'b0, 1'b0);
        step(1'b0, NOP, add_i, 1'b0, 1'b0);
        step(1'b0, lw0, add0, 1'b0, 1'b0);
        step(1'b0, lw5, sw_i, 1'b0, 1'b0);
        step(1'b0, lw5, add_i, 1'b1, 1'b0);
        step(1'b0, NOP, NOP, 1'b0, 1'b0);

        // randomized traffic; D/X holds while the op is in flight
        cur_dx = NOP;
        rdelay = 1;
        for (int c = 0; c < 3000; c++) begin
            logic r, fl, rdy;
            logic [31:0] fd;
            tick();
            r  = ($urandom_range(0, 299) == 0);
            if (!(m_inflight || m_latch)) cur_dx = rand_instr();
            fd = rand_instr();
            fl = ($urandom_range(0, 5) == 0);
            if (m_inflight) rdy = ((m_age + 1) == rdelay);
            else            rdy = ($urandom_range(0, 9) == 0);
            apply(r, cur_dx, fd, fl, rdy);
            if (last_exp[8] || last_exp[7])
                rdelay = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, 12);
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
